ps2_key_event: RTL and testbench

//   Downstream of the PS/2 receiver. Pops raw scan bytes via its ready/nextdata_n handshake.

---
 rtl/ps2_pkg.sv | 47 ++++
 rtl/ps2_key_event_sync_fifo.sv | 64 ++++++
 rtl/ps2_key_event.sv | 187 ++++++++++++++++++
 tb/tb_ps2_key_event.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ============================================================================
// Package : ps2_pkg
// Brief   : Scan-code constants, prefix-FSM states and event record for PS/2.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Keyboard-to-host control bytes that never describe a key
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  typedef struct packed {
    logic       rpt;
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  localparam int EV_W = $bits(ev_t);

  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == SC_BAT_OK) || (b == SC_ACK)    || (b == SC_ECHO) ||
           (b == SC_RESEND) || (b == SC_ERR0)   || (b == SC_ERR1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_key_event_sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO; a push into a full FIFO is kept only with a pop.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  // Extra pointer MSB distinguishes full from empty when the indices coincide
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        r_wr_ptr                <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = w_empty;
  assign o_drop  = i_push && !w_do_push;

endmodule

`default_nettype wire

// File: rtl/ps2_key_event.sv
// ============================================================================
// Module : ps2_key_event
// Brief  : Folds E0/F0 prefixes into key events, tracks modifiers, buffers events.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ps2_key_event
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  output logic       kb_nextdata_n,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       ev_repeat,
  output logic       shift_held,
  output logic       caps_lock,
  output logic [7:0] press_count,
  output logic       ev_overflow
);

  state_t     r_state;
  logic       r_last_valid;
  logic       r_last_ext;
  logic [7:0] r_last_code;
  logic       r_lshift;
  logic       r_rshift;
  logic       r_caps;
  logic [7:0] r_press_count;
  logic       r_overflow;

  state_t     w_next_state;
  logic       w_emit;
  logic       w_ext;
  logic       w_brk;
  logic       w_event;
  logic       w_match;
  logic       w_make;
  logic       w_break;
  logic       w_repeat;
  logic       w_new_make;
  ev_t        w_ev_in;
  ev_t        w_ev_out;
  logic       w_fifo_empty;
  logic       w_fifo_drop;

  always_comb begin
    w_next_state = r_state;
    w_emit       = 1'b0;
    w_ext        = 1'b0;
    w_brk        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (kb_data == SC_EXT) begin
          w_next_state = ST_EXT;
        end else if (kb_data == SC_BRK) begin
          w_next_state = ST_BRK;
        end else if (!is_ctrl(kb_data)) begin
          w_emit = 1'b1;
        end
      end
      ST_EXT: begin
        if (kb_data == SC_BRK) begin
          w_next_state = ST_EXT_BRK;
        end else if (kb_data != SC_EXT) begin
          w_emit       = 1'b1;
          w_ext        = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_BRK: begin
        if (kb_data == SC_EXT) begin
          w_next_state = ST_EXT;
        end else begin
          w_emit       = 1'b1;
          w_brk        = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_EXT_BRK: begin
        if (kb_data == SC_EXT) begin
          w_next_state = ST_EXT;
        end else begin
          w_emit       = 1'b1;
          w_ext        = 1'b1;
          w_brk        = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (kb_ready) begin
      r_state <= w_next_state;
    end
  end

  assign w_event    = kb_ready && w_emit;
  assign w_match    = r_last_valid && (r_last_ext == w_ext) && (r_last_code == kb_data);
  assign w_make     = w_event && !w_brk;
  assign w_break    = w_event && w_brk;
  assign w_repeat   = w_make && w_match;
  assign w_new_make = w_make && !w_match;

  // Key state follows the byte stream even when the FIFO has to drop the event
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_valid  <= 1'b0;
      r_last_ext    <= 1'b0;
      r_last_code   <= 8'h00;
      r_lshift      <= 1'b0;
      r_rshift      <= 1'b0;
      r_caps        <= 1'b0;
      r_press_count <= 8'h00;
      r_overflow    <= 1'b0;
    end else begin
      if (w_new_make) begin
        r_last_valid  <= 1'b1;
        r_last_ext    <= w_ext;
        r_last_code   <= kb_data;
        r_press_count <= r_press_count + 8'd1;
        if (!w_ext && (kb_data == SC_CAPS)) begin
          r_caps <= ~r_caps;
        end
      end else if (w_break && w_match) begin
        r_last_valid <= 1'b0;
      end
      if (w_event && !w_ext && (kb_data == SC_LSHIFT)) begin
        r_lshift <= !w_brk;
      end
      if (w_event && !w_ext && (kb_data == SC_RSHIFT)) begin
        r_rshift <= !w_brk;
      end
      if (w_fifo_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    w_ev_in      = '0;
    w_ev_in.rpt  = w_repeat;
    w_ev_in.ext  = w_ext;
    w_ev_in.brk  = w_brk;
    w_ev_in.code = kb_data;
  end

  sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_event),
    .i_din   (w_ev_in),
    .i_pop   (ev_ready),
    .o_dout  (w_ev_out),
    .o_empty (w_fifo_empty),
    .o_drop  (w_fifo_drop)
  );

  assign kb_nextdata_n = !(kb_ready && rst_n);
  assign ev_valid      = !w_fifo_empty;
  assign ev_code       = w_ev_out.code;
  assign ev_ext        = w_ev_out.ext;
  assign ev_break      = w_ev_out.brk;
  assign ev_repeat     = w_ev_out.rpt;
  assign shift_held    = r_lshift || r_rshift;
  assign caps_lock     = r_caps;
  assign press_count   = r_press_count;
  assign ev_overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_event.sv
// ============================================================================
// Module : tb_ps2_key_event
// Brief  : Directed and random byte streams against a prefix-flag event model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_key_event;

  localparam int DEPTH = 4;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] kb_data  = 8'h00;
  logic       kb_ready = 1'b0;
  logic       ev_ready = 1'b0;
  logic       kb_nextdata_n;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       ev_repeat;
  logic       shift_held;
  logic       caps_lock;
  logic [7:0] press_count;
  logic       ev_overflow;

  ps2_key_event #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .kb_data       (kb_data),
    .kb_ready      (kb_ready),
    .kb_nextdata_n (kb_nextdata_n),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_code       (ev_code),
    .ev_ext        (ev_ext),
    .ev_break      (ev_break),
    .ev_repeat     (ev_repeat),
    .shift_held    (shift_held),
    .caps_lock     (caps_lock),
    .press_count   (press_count),
    .ev_overflow   (ev_overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending-prefix flags, held-key tuple, event queue {rpt,ext,brk,code}
  logic [10:0] mq[$];
  bit          p_ext, p_brk;
  bit          m_last_v, m_last_ext;
  logic [7:0]  m_last_code;
  bit          m_ls, m_rs, m_caps, m_ovf;
  logic [7:0]  m_cnt;
  logic [7:0]  ctrl_tab [6] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    p_ext = 0; p_brk = 0;
    m_last_v = 0; m_last_ext = 0; m_last_code = 8'h00;
    m_ls = 0; m_rs = 0; m_caps = 0; m_ovf = 0; m_cnt = 8'h00;
  endtask

  task automatic model_edge(input logic [7:0] b, input logic rdy, input logic er);
    bit          pop, emit, ext, brk, rep;
    logic [10:0] ev;
    pop  = (mq.size() != 0) && er;
    emit = 0; ext = 0; brk = 0; rep = 0;
    if (rdy) begin
      if (b == 8'hE0) begin
        p_ext = 1; p_brk = 0;
      end else if (b == 8'hF0 && !p_brk) begin
        p_brk = 1;
      end else if (!p_ext && !p_brk && (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
        emit = 0;
      end else begin
        emit = 1; ext = p_ext; brk = p_brk;
        p_ext = 0; p_brk = 0;
      end
    end
    if (emit) begin
      bit same;
      same = m_last_v && (m_last_ext == ext) && (m_last_code == b);
      if (!brk) begin
        rep = same;
        if (!same) begin
          m_last_v = 1; m_last_ext = ext; m_last_code = b;
          m_cnt = m_cnt + 8'd1;
          if (!ext && b == 8'h58) m_caps = !m_caps;
        end
      end else if (same) begin
        m_last_v = 0;
      end
      if (!ext && b == 8'h12) m_ls = !brk;
      if (!ext && b == 8'h59) m_rs = !brk;
    end
    if (pop) void'(mq.pop_front());
    if (emit) begin
      ev = {rep, ext, brk, b};
      if (mq.size() < DEPTH) mq.push_back(ev);
      else m_ovf = 1;
    end
  endtask

  task automatic check_all(input logic rdy);
    chk("kb_nextdata_n", 32'(kb_nextdata_n), 32'(!rdy));
    chk("ev_valid", 32'(ev_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("ev_head", 32'({ev_repeat, ev_ext, ev_break, ev_code}), 32'(mq[0]));
    chk("shift_held", 32'(shift_held), 32'(m_ls || m_rs));
    chk("caps_lock", 32'(caps_lock), 32'(m_caps));
    chk("press_count", 32'(press_count), 32'(m_cnt));
    chk("ev_overflow", 32'(ev_overflow), 32'(m_ovf));
  endtask

  task automatic drive(input logic [7:0] b, input logic rdy, input logic er);
    @(negedge clk);
    rst_n = 1'b1; kb_data = b; kb_ready = rdy; ev_ready = er;
    #1;
    check_all(rdy);
    model_edge(b, rdy, er);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; kb_ready = 1'b0; ev_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'($urandom_range(0, 255)), 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] seq5 [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    model_reset();

    // Reset state, then make/break of 1C
    do_reset();
    drive(8'h00, 1'b0, 1'b0);
    drive(8'h1C, 1'b1, 1'b1);
    drive(8'hF0, 1'b1, 1'b1);
    drive(8'h1C, 1'b1, 1'b1);
    idle(3);
    chk("t1_press_count", 32'(press_count), 32'd1);

    // Extended make/break, prefixes produce nothing
    do_reset();
    drive(8'hE0, 1'b1, 1'b0);
    drive(8'h75, 1'b1, 1'b0);
    drive(8'hE0, 1'b1, 1'b0);
    drive(8'hF0, 1'b1, 1'b0);
    drive(8'h75, 1'b1, 1'b0);
    idle(4);

    // Typematic repeats
    do_reset();
    for (int i = 0; i < 3; i++) drive(8'h1C, 1'b1, 1'b1);
    drive(8'hF0, 1'b1, 1'b1);
    drive(8'h1C, 1'b1, 1'b1);
    idle(3);
    chk("t3_press_count", 32'(press_count), 32'd1);

    // Shift and caps
    do_reset();
    drive(8'h12, 1'b1, 1'b1);
    chk("t4_shift_down", 32'(shift_held), 32'd1);
    drive(8'h1C, 1'b1, 1'b1);
    drive(8'hF0, 1'b1, 1'b1);
    drive(8'h12, 1'b1, 1'b1);
    chk("t4_shift_up", 32'(shift_held), 32'd0);
    drive(8'h58, 1'b1, 1'b1);
    chk("t4_caps_on", 32'(caps_lock), 32'd1);
    drive(8'hF0, 1'b1, 1'b1);
    drive(8'h58, 1'b1, 1'b1);
    drive(8'h58, 1'b1, 1'b1);
    idle(2);
    chk("t4_caps_off", 32'(caps_lock), 32'd0);
    chk("t4_press_count", 32'(press_count), 32'd4);

    // Overflow with the consumer stalled
    do_reset();
    for (int i = 0; i < 5; i++) drive(seq5[i], 1'b1, 1'b0);
    chk("t5_overflow", 32'(ev_overflow), 32'd1);
    idle(5);
    chk("t5_drained", 32'(ev_valid), 32'd0);
    chk("t5_overflow_sticky", 32'(ev_overflow), 32'd1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 4; i++) drive(seq5[i], 1'b1, 1'b0);
    drive(8'h2C, 1'b1, 1'b1);
    chk("t5b_no_overflow", 32'(ev_overflow), 32'd0);
    idle(5);

    // Reset after a dangling E0
    do_reset();
    drive(8'h1C, 1'b1, 1'b0);
    drive(8'hE0, 1'b1, 1'b0);
    do_reset();
    drive(8'h1C, 1'b1, 1'b0);
    chk("t6_head", 32'({ev_repeat, ev_ext, ev_break, ev_code}), 32'({3'b000, 8'h1C}));
    idle(2);

    // press_count wrap
    do_reset();
    for (int i = 0; i < 256; i++) drive((i % 2) ? 8'h1D : 8'h1C, 1'b1, 1'b1);
    chk("wrap_zero", 32'(press_count), 32'd0);
    drive(8'h1C, 1'b1, 1'b1);
    chk("wrap_one", 32'(press_count), 32'd1);
    idle(2);

    // Random stream against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] b;
      int         r;
      r = int'($urandom_range(0, 11));
      case (r)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = 8'h12;
        5:       b = 8'h59;
        6:       b = 8'h58;
        7, 8:    b = ($urandom_range(0, 1) == 0) ? 8'h1C : 8'h75;
        9:       b = ctrl_tab[$urandom_range(0, 5)];
        default: b = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 199) == 0) do_reset();
      drive(b, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 4));
    end
    idle(DEPTH + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
